// File: rtl/svm_detect.sv
// svm_detect: biases and thresholds the SVM window-score stream, queues
// (x, y, score) hits in a FIFO and emits each one as a two-word packet.
// Optional build macro SVM_DETECT_NMS_EN adds 1-D horizontal non-max
// suppression; without it every hit is emitted.
module svm_detect #(
   parameter int unsigned NCOLS     = 32,
   parameter int unsigned FIFODEPTH = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_fv,
   input  logic        in_dv,
   input  logic [31:0] in_data,
   output logic        out_fv,
   output logic        out_dv,
   output logic [31:0] out_data,
   input  logic [1:0]  addr_rel_i,
   input  logic        wr_i,
   input  logic [31:0] datawr_i,
   input  logic        rd_i,
   output logic [31:0] datard_o
);

   localparam int unsigned XW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
   localparam int unsigned AW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
   localparam logic [XW-1:0] XMAX = XW'(NCOLS - 1);

   typedef enum logic [1:0] {IDLE, W0, W1} state_e;

   logic        enable_q;
   logic [31:0] thresh_q, bias_q, datard_q;
   logic        fv_q, fv_rise_c, acc_c;
   logic [XW-1:0] x_q, cur_x_c;
   logic [15:0] y_q, cur_y_c;
   logic [15:0] det_cnt_q, drop_cnt_q, det_base_c, drop_base_c;
   logic [32:0] sum_c;
   logic [31:0] s_c;
   logic        hit_c, push_c, push_ok_c, pop_c, pending_c;
   logic [63:0] push_rec_c;
   logic [63:0] mem_q [FIFODEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic        full_c, empty_c;
   logic [63:0] head_c;
   logic [31:0] next_xy_c;
   state_e      state_q, state_d;
   logic        out_fv_q, out_dv_q, out_dv_d;
   logic [31:0] out_data_q, out_data_d;

   assign fv_rise_c = in_fv & ~fv_q;
   assign acc_c     = in_fv & in_dv;
   assign cur_x_c   = fv_rise_c ? '0 : x_q;
   assign cur_y_c   = fv_rise_c ? '0 : y_q;

   // Bias add with 32-bit signed saturation, then strict threshold compare
   assign sum_c = {in_data[31], in_data} + {bias_q[31], bias_q};
   assign s_c   = (sum_c[32] != sum_c[31]) ? (sum_c[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                           : sum_c[31:0];
   assign hit_c = enable_q && ($signed(s_c) > $signed(thresh_q));

   // Register bus writes and registered read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_q <= 1'b0;
         thresh_q <= '0;
         bias_q   <= '0;
         datard_q <= '0;
      end else begin
         if (wr_i) begin
            case (addr_rel_i)
               2'd0:    enable_q <= datawr_i[0];
               2'd1:    thresh_q <= datawr_i;
               2'd2:    bias_q   <= datawr_i;
               default: ;
            endcase
         end
         if (rd_i) begin
            case (addr_rel_i)
               2'd0:    datard_q <= {31'd0, enable_q};
               2'd1:    datard_q <= thresh_q;
               2'd2:    datard_q <= bias_q;
               default: datard_q <= {drop_cnt_q, det_cnt_q};
            endcase
         end
      end
   end

   // Window position tracking; a frame start restarts at (0, 0)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fv_q <= 1'b0;
         x_q  <= '0;
         y_q  <= '0;
      end else begin
         fv_q <= in_fv;
         if (acc_c) begin
            if (cur_x_c == XMAX) begin
               x_q <= '0;
               y_q <= cur_y_c + 16'd1;
            end else begin
               x_q <= cur_x_c + 1'b1;
               y_q <= cur_y_c;
            end
         end else if (fv_rise_c) begin
            x_q <= '0;
            y_q <= '0;
         end
      end
   end

`ifdef SVM_DETECT_NMS_EN
   logic          fv_fall_c, cand_v_q, cand_ok_q, cand_live_c, left_ok_c;
   logic [XW-1:0] cand_x_q;
   logic [15:0]   cand_y_q;
   logic [31:0]   cand_s_q, prev_s_q;

   assign fv_fall_c   = ~in_fv & fv_q;
   assign cand_live_c = cand_v_q & ~fv_rise_c;
   assign left_ok_c   = (cur_x_c == '0) || ($signed(s_c) > $signed(prev_s_q));
   assign pending_c   = cand_v_q;

   // Held candidate resolves against its right neighbour, row end or frame end
   always_comb begin
      push_c     = 1'b0;
      push_rec_c = '0;
      if (acc_c) begin
         if (cand_live_c && cand_ok_q && ($signed(cand_s_q) >= $signed(s_c))) begin
            push_c     = 1'b1;
            push_rec_c = {cand_y_q, 16'(cand_x_q), cand_s_q};
         end else if ((cur_x_c == XMAX) && hit_c && left_ok_c) begin
            push_c     = 1'b1;
            push_rec_c = {cur_y_c, 16'(cur_x_c), s_c};
         end
      end else if (fv_fall_c && cand_v_q && cand_ok_q) begin
         push_c     = 1'b1;
         push_rec_c = {cand_y_q, 16'(cand_x_q), cand_s_q};
      end
   end

   // Candidate and left-neighbour score registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand_v_q  <= 1'b0;
         cand_ok_q <= 1'b0;
         cand_x_q  <= '0;
         cand_y_q  <= '0;
         cand_s_q  <= '0;
         prev_s_q  <= '0;
      end else if (acc_c) begin
         cand_v_q  <= (cur_x_c != XMAX);
         cand_ok_q <= hit_c && left_ok_c;
         cand_x_q  <= cur_x_c;
         cand_y_q  <= cur_y_c;
         cand_s_q  <= s_c;
         prev_s_q  <= s_c;
      end else if (fv_fall_c || fv_rise_c) begin
         cand_v_q  <= 1'b0;
      end
   end
`else
   // Every hit goes straight to the FIFO
   always_comb begin
      push_c     = acc_c && hit_c;
      push_rec_c = {cur_y_c, 16'(cur_x_c), s_c};
      pending_c  = 1'b0;
   end
`endif

   assign full_c    = (cnt_q == (AW+1)'(FIFODEPTH));
   assign empty_c   = (cnt_q == '0);
   assign pop_c     = (state_q == W1);
   assign push_ok_c = push_c && (!full_c || pop_c);
   assign head_c    = mem_q[rd_ptr_q];
   assign next_xy_c = mem_q[AW'(rd_ptr_q + 1'b1)][63:32];
   assign det_base_c  = fv_rise_c ? '0 : det_cnt_q;
   assign drop_base_c = fv_rise_c ? '0 : drop_cnt_q;

   // Record storage
   always_ff @(posedge clk) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= push_rec_c;
   end

   // FIFO pointers plus saturating detect/drop counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         det_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (push_ok_c) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_c)     rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(push_ok_c) - (AW+1)'(pop_c);
         det_cnt_q  <= (push_ok_c && det_base_c != 16'hFFFF) ? det_base_c + 16'd1 : det_base_c;
         drop_cnt_q <= (push_c && !push_ok_c && drop_base_c != 16'hFFFF) ?
                       drop_base_c + 16'd1 : drop_base_c;
      end
   end

   // Output packet sequencer: next state and next output words
   always_comb begin
      state_d    = state_q;
      out_dv_d   = 1'b0;
      out_data_d = '0;
      case (state_q)
         IDLE: begin
            if (!empty_c) begin
               state_d    = W0;
               out_dv_d   = 1'b1;
               out_data_d = head_c[63:32];
            end
         end
         W0: begin
            state_d    = W1;
            out_dv_d   = 1'b1;
            out_data_d = head_c[31:0];
         end
         W1: begin
            if (cnt_q > (AW+1)'(1)) begin
               state_d    = W0;
               out_dv_d   = 1'b1;
               out_data_d = next_xy_c;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer state, registered outputs and frame-valid stretch
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         out_dv_q   <= 1'b0;
         out_data_q <= '0;
         out_fv_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_dv_q   <= out_dv_d;
         out_data_q <= out_data_d;
         out_fv_q   <= in_fv | (out_fv_q & ~(empty_c & (state_q == IDLE) & ~pending_c));
      end
   end

   assign out_fv   = out_fv_q;
   assign out_dv   = out_dv_q;
   assign out_data = out_data_q;
   assign datard_o = datard_q;

endmodule

// File: tb/tb_svm_detect.sv
// Directed bench for svm_detect: register access, bias/threshold hits,
// saturation, overflow, row wrap, frame restart and reset abort.
module tb_svm_detect;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_fv = 1'b0, in_dv = 1'b0;
   logic [31:0] in_data = '0;
   logic        out_fv, out_dv;
   logic [31:0] out_data;
   logic [1:0]  addr_rel_i = '0;
   logic        wr_i = 1'b0, rd_i = 1'b0;
   logic [31:0] datawr_i = '0;
   logic [31:0] datard_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] words[$];
   int cyc = 0, last_dv_cyc = 0, fv_fall_cyc = 0;
   logic fv_prev = 1'b0;
   logic [31:0] st, rv;

   always #5 clk = ~clk;

   svm_detect #(.NCOLS(32), .FIFODEPTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .in_fv(in_fv), .in_dv(in_dv), .in_data(in_data),
      .out_fv(out_fv), .out_dv(out_dv), .out_data(out_data),
      .addr_rel_i(addr_rel_i), .wr_i(wr_i), .datawr_i(datawr_i),
      .rd_i(rd_i), .datard_o(datard_o)
   );

   // Output word collector, sampled on the falling edge
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (out_dv === 1'b1) begin
         words.push_back(out_data);
         last_dv_cyc = cyc;
      end
      if (fv_prev === 1'b1 && out_fv === 1'b0) fv_fall_cyc = cyc;
      fv_prev = out_fv;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      addr_rel_i = a; datawr_i = d; wr_i = 1'b1;
      tick();
      wr_i = 1'b0;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
      addr_rel_i = a; rd_i = 1'b1;
      tick();
      rd_i = 1'b0;
      d = datard_o;
   endtask

   task automatic send(input logic [31:0] d);
      in_dv = 1'b1; in_data = d;
      tick();
      in_dv = 1'b0;
   endtask

   task automatic start_frame();
      in_fv = 1'b1;
      tick();
   endtask

   task automatic end_frame();
      in_fv = 1'b0;
      for (int i = 0; i < 300 && out_fv === 1'b1; i++) tick();
      tick();
      check("frame_end_out_fv", 32'(out_fv), 32'd0);
   endtask

   initial begin
      // Reset state
      tick(); tick();
      check("rst_out_fv",   32'(out_fv), 32'd0);
      check("rst_out_dv",   32'(out_dv), 32'd0);
      check("rst_out_data", out_data,    32'd0);
      check("rst_datard",   datard_o,    32'd0);
      reset_n = 1'b1;
      tick();
      rd_reg(2'd3, st);
      check("rst_status", st, 32'd0);

      // One row 0..31 with 150 at x=5, threshold 100
      wr_reg(2'd0, 32'd1);
      wr_reg(2'd1, 32'd100);
      wr_reg(2'd2, 32'd0);
      rd_reg(2'd1, rv);
      check("rd_thresh", rv, 32'd100);
      words.delete();
      start_frame();
      for (int x = 0; x < 32; x++) send((x == 5) ? 32'd150 : 32'(x));
      end_frame();
      check("t1_nwords", 32'(words.size()), 32'd2);
      if (words.size() >= 2) begin
         check("t1_w0", words[0], 32'h0000_0005);
         check("t1_w1", words[1], 32'd150);
      end
      rd_reg(2'd3, st);
      check("t1_status", st, 32'h0000_0001);

`ifdef SVM_DETECT_NMS_EN
      // Horizontal NMS: only x=1 survives
      wr_reg(2'd1, 32'd150);
      words.delete();
      start_frame();
      send(32'd200); send(32'd300); send(32'd300); send(32'd100);
      end_frame();
      check("nms_nwords", 32'(words.size()), 32'd2);
      if (words.size() >= 2) begin
         check("nms_w0", words[0], 32'h0000_0001);
         check("nms_w1", words[1], 32'd300);
      end
`else
      // Saturation, exact latency and equal-to-threshold rejection
      wr_reg(2'd2, 32'h7FFF_FFF0);
      wr_reg(2'd1, 32'd0);
      words.delete();
      start_frame();
      send(32'h7FFF_FFF0);
      check("lat_t1_dv", 32'(out_dv), 32'd0);
      tick();
      check("lat_w0_dv", 32'(out_dv), 32'd1);
      check("lat_w0_xy", out_data, 32'h0000_0000);
      tick();
      check("lat_w1_dv", 32'(out_dv), 32'd1);
      check("lat_w1_sat", out_data, 32'h7FFF_FFFF);
      send(32'h8000_0010);
      end_frame();
      check("t2_nwords", 32'(words.size()), 32'd2);

      // 40 back-to-back hits overflow the FIFO
      wr_reg(2'd2, 32'd0);
      words.delete();
      start_frame();
      for (int i = 0; i < 40; i++) send(32'd1000 + 32'(i));
      end_frame();
      rd_reg(2'd3, st);
      check("t3_sum", 32'(st[15:0]) + 32'(st[31:16]), 32'd40);
      check("t3_drop_nz", 32'(st[31:16] != 16'd0), 32'd1);
      check("t3_nwords", 32'(words.size()), 32'(st[15:0]) * 2);
      check("t3_fv_after_w1", 32'(fv_fall_cyc > last_dv_cyc), 32'd1);
      begin
         int prev = -1;
         for (int p = 0; p + 1 < words.size(); p += 2) begin
            int idx;
            idx = int'(words[p+1]) - 1000;
            check("t3_order", 32'(idx > prev), 32'd1);
            check("t3_xy", words[p], {16'(idx / 32), 16'(idx % 32)});
            prev = idx;
         end
      end

      // Row wrap: x=31 row 0 and x=0 row 1
      wr_reg(2'd1, 32'd100);
      words.delete();
      start_frame();
      for (int x = 0; x < 32; x++) send((x == 31) ? 32'd200 : 32'd0);
      send(32'd300); send(32'd0); send(32'd0);
      end_frame();
      check("t4_nwords", 32'(words.size()), 32'd4);
      if (words.size() >= 4) begin
         check("t4_p0_xy", words[0], 32'h0000_001F);
         check("t4_p0_s",  words[1], 32'd200);
         check("t4_p1_xy", words[2], 32'h0001_0000);
         check("t4_p1_s",  words[3], 32'd300);
      end
      rd_reg(2'd3, st);
      check("t4_status", st, 32'h0000_0002);

      // Frame restart clears y and counters
      words.delete();
      start_frame();
      send(32'd500);
      end_frame();
      check("t5_nwords", 32'(words.size()), 32'd2);
      if (words.size() >= 2) begin
         check("t5_xy", words[0], 32'h0000_0000);
         check("t5_s",  words[1], 32'd500);
      end
      rd_reg(2'd3, st);
      check("t5_status", st, 32'h0000_0001);
`endif

      // Reset during W0 aborts the packet immediately
      wr_reg(2'd1, 32'd100);
      wr_reg(2'd2, 32'd0);
      start_frame();
      send(32'd200);
`ifdef SVM_DETECT_NMS_EN
      send(32'd0);
`endif
      tick();
      check("rst_pre_w0_dv", 32'(out_dv), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rst_abort_dv", 32'(out_dv), 32'd0);
      check("rst_abort_fv", 32'(out_fv), 32'd0);
      #1;
      reset_n = 1'b1;
      in_fv = 1'b0;
      tick();
      words.delete();
      rd_reg(2'd1, rv);
      check("rst_thresh_zero", rv, 32'd0);
      rd_reg(2'd0, rv);
      check("rst_enable_zero", rv, 32'd0);
      start_frame();
      send(32'd500); send(32'd600);
      end_frame();
      check("rst_no_leftover", 32'(words.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
